// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: groups ADC channel words into frames, keeps a circular
// pre-trigger history, captures post-trigger frames on a channel-0 magnitude
// threshold, then replays the frozen window oldest-first over valid/ready.
// Optional feature macro: SFB_TIMESTAMP_EN (adds cycle counter and trig_time).
module sample_frame_buffer #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned POST   = 192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      busy,
    input  logic                      write,
    input  logic [15:0]               toMem,
    input  logic                      arm,
    input  logic [15:0]               threshold,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [15:0]               rd_data,
    output logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic [1:0]                state,
    output logic                      triggered,
    output logic                      overflow
`ifdef SFB_TIMESTAMP_EN
    ,
    output logic [31:0]               trig_time
`endif
);

    localparam int unsigned CW    = $clog2(NUM_CH);
    localparam int unsigned FW    = $clog2(DEPTH);
    localparam int unsigned AW    = CW + FW;
    localparam int unsigned RCW   = AW + 1;
    localparam int unsigned FILLW = $clog2(DEPTH + 1);
    localparam int unsigned PW    = $clog2(POST + 1);

    localparam logic [FILLW-1:0] FILL_MAX  = FILLW'(DEPTH - POST);
    localparam logic [PW-1:0]    POST_LAST = PW'(POST - 1);
    localparam logic [CW-1:0]    CH_LAST   = CW'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRE     = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    logic [1:0]       state_d;
    logic             busy_q;
    logic [CW-1:0]    ch_idx;
    logic             frame_full;
    logic [FW-1:0]    wr_frame;
    logic [FILLW-1:0] fill;
    logic [PW-1:0]    post_cnt;

    logic             busy_rise;
    logic             capturing;
    logic [CW-1:0]    ch_eff;
    logic             full_eff;
    logic             wr_en;
    logic             wr_drop;
    logic             frame_done;
    logic [16:0]      mag;
    logic             trig_hit;
    logic             post_end;
    logic [AW-1:0]    wr_addr;

    logic [15:0]      mem [NUM_CH*DEPTH];
    logic [RCW-1:0]   rd_cnt;
    logic [FW-1:0]    rd_frame;
    logic [AW-1:0]    rd_addr;
    logic             rd_issue;
    logic             rd_last;
    logic             fire;
    logic [1:0]       occ;
    logic             ram_vld;
    logic [15:0]      ram_q;
    logic [CW-1:0]    ram_ch;
    logic             sk_valid;
    logic [15:0]      sk_data;
    logic [CW-1:0]    sk_ch;

    // Write-side decode: a busy edge in the same cycle as a write lands the word at channel 0
    always_comb begin
        busy_rise  = busy & ~busy_q;
        capturing  = (state == S_PRE) || (state == S_POST);
        ch_eff     = busy_rise ? '0 : ch_idx;
        full_eff   = busy_rise ? 1'b0 : frame_full;
        wr_en      = write & capturing & ~full_eff;
        wr_drop    = write & capturing & full_eff;
        frame_done = wr_en & (ch_eff == CH_LAST);
        mag        = toMem[15] ? (17'd0 - {toMem[15], toMem}) : {1'b0, toMem};
        trig_hit   = (state == S_PRE) & wr_en & (ch_eff == '0) &
                     (fill == FILL_MAX) & (mag >= {1'b0, threshold});
        post_end   = (state == S_POST) & frame_done & (post_cnt == POST_LAST);
        wr_addr    = {wr_frame, ch_eff};
    end

    // Read-side decode: at most two words buffered or in flight beyond the output
    always_comb begin
        fire     = rd_valid & rd_ready;
        occ      = {1'b0, rd_valid} + {1'b0, sk_valid} + {1'b0, ram_vld} - {1'b0, fire};
        rd_issue = (state == S_READOUT) & ~rd_cnt[AW] & (occ < 2'd2);
        rd_last  = (state == S_READOUT) & fire & rd_cnt[AW] & ~sk_valid & ~ram_vld;
        rd_frame = wr_frame + rd_cnt[AW-1:CW];
        rd_addr  = {rd_frame, rd_cnt[CW-1:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (arm)      state_d = S_PRE;
            S_PRE:     if (trig_hit) state_d = S_POST;
            S_POST:    if (post_end) state_d = S_READOUT;
            S_READOUT: if (rd_last)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Frame tracking, fill/post counters and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            ch_idx     <= '0;
            frame_full <= 1'b0;
            wr_frame   <= '0;
            fill       <= '0;
            post_cnt   <= '0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            busy_q <= busy;
            if ((state == S_IDLE) && arm) begin
                ch_idx     <= '0;
                frame_full <= 1'b0;
                wr_frame   <= '0;
                fill       <= '0;
                post_cnt   <= '0;
                triggered  <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (busy_rise) begin
                    ch_idx     <= '0;
                    frame_full <= 1'b0;
                end
                if (wr_en) begin
                    ch_idx <= ch_eff + CW'(1);
                    if (ch_eff == CH_LAST) begin
                        frame_full <= 1'b1;
                        wr_frame   <= wr_frame + FW'(1);
                    end
                end
                if (wr_drop) overflow <= 1'b1;
                if ((state == S_PRE) && frame_done && (fill != FILL_MAX))
                    fill <= fill + FILLW'(1);
                if (trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= '0;
                end else if ((state == S_POST) && frame_done) begin
                    post_cnt <= post_cnt + PW'(1);
                end
            end
        end
    end

    // Sample RAM: write port from the frame stream, registered read port for replay
    always_ff @(posedge clk) begin
        if (wr_en)    mem[wr_addr] <= toMem;
        if (rd_issue) ram_q <= mem[rd_addr];
    end

    // Replay address counter and in-flight read tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt  <= '0;
            ram_vld <= 1'b0;
            ram_ch  <= '0;
        end else begin
            ram_vld <= rd_issue;
            if (rd_issue) ram_ch <= rd_cnt[CW-1:0];
            if (state != S_READOUT) rd_cnt <= '0;
            else if (rd_issue)      rd_cnt <= rd_cnt + RCW'(1);
        end
    end

    // Output register plus one-entry skid to sustain one word per cycle under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ch    <= '0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
            sk_ch    <= '0;
        end else if (!rd_valid || rd_ready) begin
            if (sk_valid) begin
                rd_valid <= 1'b1;
                rd_data  <= sk_data;
                rd_ch    <= sk_ch;
                sk_valid <= ram_vld;
                sk_data  <= ram_q;
                sk_ch    <= ram_ch;
            end else if (ram_vld) begin
                rd_valid <= 1'b1;
                rd_data  <= ram_q;
                rd_ch    <= ram_ch;
            end else begin
                rd_valid <= 1'b0;
            end
        end else if (ram_vld) begin
            sk_valid <= 1'b1;
            sk_data  <= ram_q;
            sk_ch    <= ram_ch;
        end
    end

`ifdef SFB_TIMESTAMP_EN
    logic [31:0] cyc_cnt;

    // Free-running cycle counter, latched when the trigger is registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt   <= '0;
            trig_time <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if ((state == S_IDLE) && arm) trig_time <= '0;
            else if (trig_hit)            trig_time <= cyc_cnt;
        end
    end
`endif

endmodule

// File: doc/sample_frame_buffer.md
# sample_frame_buffer

Downstream consumer of the ADC driver's `toMem`/`write` sample stream. Groups the per-conversion channel words into frames and records them into a circular pre-trigger buffer. Fires on a channel-0 magnitude threshold and captures a fixed number of post-trigger frames, then freezes. The frozen window is replayed oldest-first over a valid/ready port to the localization DSP.

## Interface
- `NUM_CH`, 8: channels per conversion frame (power of two, 2..8)
- `DEPTH`, 256: frames held in the ring (power of two)
- `POST`, 192: frames captured from the trigger frame onward (1..DEPTH)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `busy`  in  1  ADC BUSY; its rising edge starts a new frame
- `write`  in  1  one-cycle strobe, one per sample word from the driver
- `toMem`  in  16  sample word, two's complement
- `arm`  in  1  one-cycle pulse; starts a capture from IDLE
- `threshold`  in  16  unsigned trigger magnitude
- `rd_ready`  in  1  consumer accepts `rd_data`
- `rd_valid`  out  1  `rd_data`/`rd_ch` hold a valid word
- `rd_data`  out  16  replayed sample
- `rd_ch`  out  log2(NUM_CH)  channel index of `rd_data`
- `state`  out  2  0=IDLE, 1=PRE, 2=POST, 3=READOUT
- `triggered`  out  1  sticky; set on trigger, cleared by `arm`
- `overflow`  out  1  sticky; set on an excess word, cleared by `arm`

## Operation
- Storage is a RAM of NUM_CH*DEPTH x 16. The write address is {`wr_frame`, `ch_idx`}.
- Frame tracking:
  - A rising edge of `busy` (registered compare) sets `ch_idx`=0 and clears `frame_full`.
  - Each accepted `write` stores `toMem` and increments `ch_idx`.
  - A write at `ch_idx`=NUM_CH-1 completes the frame: `wr_frame` advances modulo DEPTH and `frame_full` is set.
  - A `write` while `frame_full` is set is dropped and sets `overflow`.
  - If the `busy` edge and `write` occur in the same cycle, the edge is applied first and the word lands at channel 0.
  - A partial frame (busy edge before channel NUM_CH-1) is overwritten; `wr_frame` is not advanced.
- IDLE:
  - Writes are ignored.
  - `arm` clears `triggered`, `overflow`, `wr_frame`, `ch_idx` and `fill`, then moves to PRE.
- PRE:
  - Writes are stored and `fill` counts completed frames, saturating at DEPTH-POST.
  - Trigger condition: channel-0 word with |`toMem`| >= `threshold` while `fill` = DEPTH-POST.
  - Magnitude is computed at 17 bits, so -32768 gives 32768. `threshold`=0 fires on the first eligible word.
  - On trigger: set `triggered`, set `post_cnt`=0, move to POST.
- POST:
  - Writes are stored. The trigger frame is post frame 1.
  - When POST frames have completed, move to READOUT and freeze `wr_frame`.
- READOUT:
  - Writes are ignored.
  - Replay covers DEPTH*NUM_CH words, frame-major then channel-minor, starting at frame `wr_frame` (the oldest) and wrapping modulo DEPTH.
  - After the final word is accepted, return to IDLE.
- `arm` outside IDLE is ignored. No abort exists; only `rst` stops a capture.

## Timing
- Write path: `toMem` is in RAM 1 cycle after `write`; the trigger decision is registered in the same cycle as the write.
- State latency: PRE->POST on the cycle after the triggering write; POST->READOUT on the cycle after the POST-th frame-completing write.
- Read path:
  - The RAM read latency is 1 cycle.
  - First `rd_valid` is 2 cycles after `state` becomes 3.
  - The prefetch skid allows one word per cycle under continuous `rd_ready`.
- Handshake rules:
  - A transfer happens when `rd_valid`&`rd_ready` are both high.
  - While `rd_valid`&!`rd_ready`, `rd_data`/`rd_ch` hold stable.
  - `rd_valid` never drops without a transfer.
- Reset values: `state`=0, `rd_valid`=0, `rd_data`=0, `rd_ch`=0, `triggered`=0, `overflow`=0, all pointers and counters 0. RAM contents are undefined.
- Reset mid-operation (any state, any cycle) returns to IDLE immediately. A pending replay is discarded.

## Configuration
- `SFB_TIMESTAMP_EN` defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps).
  - Adds output `trig_time` [31:0]: the counter value latched in the cycle the trigger is registered. Reset 0; cleared by `arm`.
- Not defined: no counter and no `trig_time` port. All other behaviour is identical.

## Test plan
- NUM_CH=8, DEPTH=4, POST=2: arm; 2 frames with ch0=100, threshold=500; third frame ch0=-600 -> `triggered`=1 and `state`=2 next cycle; after frame 4 `state`=3; replay yields 32 words, frame 1 first, `rd_ch` 0..7 repeating.
- Same config, trigger-level word in frame 1 (`fill`<2) -> no trigger; same word in frame 3 -> trigger.
- Nine `write` strobes between `busy` edges -> 9th dropped, `overflow`=1, `wr_frame` advanced exactly once; next `arm` clears `overflow`.
- ch0=-32768 with threshold=0xFFFF -> no trigger; threshold=0x8000 -> trigger.
- Readout with `rd_ready` toggling 1,0,0,1 -> `rd_data` held across stalls; no word lost or duplicated; 1 word/cycle when `rd_ready` is held high.
- `rst` low mid-POST -> all outputs at reset values asynchronously; `arm` afterward starts a clean PRE. With `SFB_TIMESTAMP_EN`, `trig_time` = cycle count at the trigger registration.
